aes_round_scheduler: RTL and testbench
======================================

Name: aes_round_scheduler

Overview:
- Parametrised recirculating round scheduler for the AES datapath.
- It admits 128-bit blocks and issues one datapath pass per cycle to an external fixed-latency round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey), then recirculates each block until its last round.
- Completed blocks are buffered in an output FIFO.
- Generalises the fixed 10-round encode pipeline:
  - per-block key length (10/12/14 rounds)
  - per-block encode/decode mode and tag
  - valid/ready handshakes on both sides
  - credit-based backpressure

Parameters:
LAT, 4, datapath latency in cycles (>=1); data issued in cycle c returns on ret_data in cycle c+LAT
TAG_W, 4, width of per-block tag
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input block offered
in_ready  out  1  input block accepted when in_valid&&in_ready
in_data  in  128  plaintext/ciphertext state
in_tag  in  TAG_W  block identifier
in_mode  in  1  1=encode, 0=decode
in_nr_sel  in  2  0:10 rounds, 1:12, 2:14, 3:10
iss_valid  out  1  datapath pass issued this cycle
iss_data  out  128  state to datapath
iss_round  out  4  round index applied by this pass (0 = initial AddRoundKey only)
iss_last  out  1  iss_round == block NR (final round, no MixColumns)
iss_mode  out  1  mode of issued block
ret_data  in  128  datapath result, valid exactly LAT cycles after issue
out_valid  out  1  completed block available
out_ready  in  1  consumer accepts
out_data  out  128  result state
out_tag  out  TAG_W  tag of result
out_mode  out  1  mode of result
busy  out  1  any block in flight or buffered

Behaviour:
- Metadata delay line of LAT entries, one per cycle: {valid, round, nr, tag, mode}. Entry at tail = pass returning this cycle. Data itself is not stored; ret_data is used directly.
- Issue priority, one issue per cycle:
  - Recirculate: tail valid && tail.round < tail.nr. Issue iss_data=ret_data, iss_round=tail.round+1, same cycle as return (combinational forward).
  - Otherwise admit: in_valid && credit_ok. Issue iss_data=in_data, iss_round=0.
- in_ready = !rst && !recirc && credit_ok. It is combinational from registered state and does not depend on in_valid.
- credit_ok = (inflight + fifo_count) < OUT_DEPTH, using registered counts. This guarantees a completing block always has FIFO space; no stall path into the datapath.
- Completion: tail valid && tail.round == tail.nr. ret_data/tag/mode are written to the FIFO at that edge, and inflight decrements.
- Completion and admission in the same cycle are legal: inflight is unchanged and fifo_count increments.
- Completion is not an issue, so the slot is free for admission.
- Pop: out_valid && out_ready. Credit is freed from the next cycle.
- Push and pop in the same cycle: fifo_count is unchanged.
- Per-block latency with no contention, handshake in cycle t:
  - round k issued in cycle t+k*LAT
  - out_valid in cycle t+(NR+1)*LAT+1
  - Example: NR=10, LAT=4 gives t+45.
- Ordering:
  - The FIFO outputs in completion order.
  - Blocks with equal NR complete in admission order.
  - A shorter-NR block may overtake a longer one; out_tag identifies it.
- nr_sel and mode are sampled at admission and held per block; later changes on inputs do not affect in-flight blocks.
- Reset, including mid-operation:
  - clears the delay line, inflight, FIFO pointers and count
  - in-flight and buffered blocks are discarded
  - while rst=1: in_ready=0, iss_valid=0
  - cycle after reset: out_valid=0, busy=0, in_ready=1
  - ret_data arriving after reset is ignored.
- Reset values: out_valid=0, iss_valid=0, busy=0, out_data/out_tag/out_mode=0.
- busy = inflight!=0 || fifo_count!=0.

Test Plan:
Bench datapath model: ret_data = iss_data ^ {124'b0, iss_round} delayed LAT; default LAT=4, OUT_DEPTH=4.
1. Single block, NR=10, tag 3, admitted at c0, out_ready=1 -> iss_round 0,1,...,10 at c0,c4,...,c40; iss_last=1 only at c40; out_valid at c45; out_data = in_data ^ 0xB; out_tag=3.
2. Four blocks admitted c0..c3, nr_sel=0 -> in_ready=0 from c4 through c44; iss_valid=1 every cycle c0..c43; outputs c45..c48 in admission order.
3. out_ready=0, offer 6 blocks -> exactly 4 admitted; in_ready stays 0 after all 4 complete; one pop at cycle p -> in_ready=1 at p+1 (no recirc pending).
4. Block A nr_sel=2 (tag 1) at c0, block B nr_sel=0 (tag 2) at c1 -> B out at c46 (data ^ 0xB); A out at c61 (data ^ 0xF).
5. nr_sel=1 block -> 13 passes, out_data = in_data ^ 0xC. nr_sel=3 block -> 11 passes, ^0xB. out_mode equals in_mode at admission for both encode and decode.
6. rst asserted at c20 with 3 blocks in flight, 1 buffered -> c21: out_valid=0, busy=0, in_ready=1; no output ever carries the discarded tags; a fresh block admitted at c21 completes at c66.

Source files
------------

// File: rtl/aes_round_scheduler.sv
// Recirculating AES round scheduler: admits blocks, issues one datapath pass per cycle, buffers results.
// Latency: round k issued LAT*k cycles after admission; out_valid (NR+1)*LAT+1 cycles after admission.
// Backpressure: admission gated by credits (inflight + buffered < OUT_DEPTH); completions never stall.
module aes_round_scheduler #(
  parameter int LAT       = 4,
  parameter int TAG_W     = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_mode,
  input  logic [1:0]       in_nr_sel,
  output logic             iss_valid,
  output logic [127:0]     iss_data,
  output logic [3:0]       iss_round,
  output logic             iss_last,
  output logic             iss_mode,
  input  logic [127:0]     ret_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_mode,
  output logic             busy
);

  localparam int PW   = $clog2(OUT_DEPTH);
  localparam int CW   = PW + 1;
  localparam int SUMW = CW + 1;
  localparam logic [SUMW-1:0] DEPTH_V = SUMW'(OUT_DEPTH);

  // Per-pass bookkeeping travelling alongside the data in the external datapath
  typedef struct packed {
    logic             vld;
    logic [3:0]       round;
    logic [3:0]       nr;
    logic [TAG_W-1:0] tag;
    logic             mode;
  } meta_t;

  typedef struct packed {
    logic [127:0]     data;
    logic [TAG_W-1:0] tag;
    logic             mode;
  } ent_t;

  meta_t         meta_q [LAT];
  meta_t         meta_d;
  meta_t         tail;
  ent_t          mem_q [OUT_DEPTH];
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SUMW-1:0] occupancy;
  logic          recirc, done, credit_ok, admit, pop;
  logic [3:0]    adm_nr;

  assign tail      = meta_q[LAT-1];
  assign recirc    = !rst && tail.vld && (tail.round < tail.nr);
  assign done      = !rst && tail.vld && (tail.round == tail.nr);
  assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign credit_ok = occupancy < DEPTH_V;
  assign in_ready  = !rst && !recirc && credit_ok;
  assign admit     = in_valid && in_ready;
  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (inflight_q != '0) || (fifo_cnt_q != '0);

  // Output bus reads zero whenever nothing is buffered
  assign out_data  = out_valid ? mem_q[rd_ptr_q].data : '0;
  assign out_tag   = out_valid ? mem_q[rd_ptr_q].tag  : '0;
  assign out_mode  = out_valid ? mem_q[rd_ptr_q].mode : 1'b0;

  // Key-length select to round count; code 3 aliases to AES-128
  always_comb begin
    case (in_nr_sel)
      2'd1:    adm_nr = 4'd12;
      2'd2:    adm_nr = 4'd14;
      default: adm_nr = 4'd10;
    endcase
  end

  // Issue arbitration: returning blocks with rounds left win over new admissions
  always_comb begin
    meta_d   = '0;
    iss_data = in_data;
    if (recirc) begin
      meta_d.vld   = 1'b1;
      meta_d.round = tail.round + 4'd1;
      meta_d.nr    = tail.nr;
      meta_d.tag   = tail.tag;
      meta_d.mode  = tail.mode;
      iss_data     = ret_data;
    end else if (admit) begin
      meta_d.vld   = 1'b1;
      meta_d.round = 4'd0;
      meta_d.nr    = adm_nr;
      meta_d.tag   = in_tag;
      meta_d.mode  = in_mode;
    end
    iss_valid = meta_d.vld;
    iss_round = meta_d.round;
    iss_last  = meta_d.vld && (meta_d.round == meta_d.nr);
    iss_mode  = meta_d.mode;
  end

  // Occupancy counters and FIFO pointer next-state
  always_comb begin
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    case ({admit, done})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    case ({done, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (done) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Metadata delay line and counters; reset discards every in-flight and buffered block
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) meta_q[i] <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      meta_q[0] <= meta_d;
      for (int i = 1; i < LAT; i++) meta_q[i] <= meta_q[i-1];
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Completed block captured straight from the datapath return bus
  always_ff @(posedge clk) begin
    if (done) begin
      mem_q[wr_ptr_q].data <= ret_data;
      mem_q[wr_ptr_q].tag  <= tail.tag;
      mem_q[wr_ptr_q].mode <= tail.mode;
    end
  end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Scoreboard bench for aes_round_scheduler with a behavioural XOR-by-round datapath.
// Directed vectors: single block, credit fill, backpressure, overtaking, key lengths, mid-run reset.
module tb_aes_round_scheduler;
  localparam int LAT       = 4;
  localparam int TAG_W     = 4;
  localparam int OUT_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic [TAG_W-1:0] in_tag;
  logic             in_mode;
  logic [1:0]       in_nr_sel;
  logic             iss_valid;
  logic [127:0]     iss_data;
  logic [3:0]       iss_round;
  logic             iss_last;
  logic             iss_mode;
  logic [127:0]     ret_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_mode;
  logic             busy;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tag;
    logic         mode;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  logic [127:0] dp [LAT];

  aes_round_scheduler #(.LAT(LAT), .TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .in_mode(in_mode), .in_nr_sel(in_nr_sel),
    .iss_valid(iss_valid), .iss_data(iss_data), .iss_round(iss_round),
    .iss_last(iss_last), .iss_mode(iss_mode), .ret_data(ret_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_mode(out_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: each pass XORs its round index into the low nibble, LAT cycles later
  always @(posedge clk) begin
    dp[0] <= iss_data ^ {124'b0, iss_round};
    for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
  end
  assign ret_data = dp[LAT-1];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted output is compared with the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got tag %0d data %h expected nothing (cycle %0d)", out_tag, out_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_tag", 128'(out_tag), 128'(e.tag));
        chk("out_mode", 128'(out_mode), 128'(e.mode));
        if (e.cyc >= 0) chk("out_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  function automatic logic [127:0] blk(input logic [7:0] s);
    return {s, 120'ha5a5_5a5a_0123_4567_89ab_cdef_0011_22};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] d, input logic [3:0] tag, input logic mode, input logic [1:0] nr);
    in_valid  = 1'b1;
    in_data   = d;
    in_tag    = tag;
    in_mode   = mode;
    in_nr_sel = nr;
  endtask

  task automatic push(input logic [127:0] d, input logic [3:0] tag, input logic mode, input int c);
    exp_t e;
    e.data = d;
    e.tag  = tag;
    e.mode = mode;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_within_budget", 128'((sb.size() == 0 && !busy) ? 1 : 0), 128'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int t;
    int cnt;
    int admitted;
    int j;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    in_mode   = 1'b0;
    in_nr_sel = 2'd0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_iss_valid", 128'(iss_valid), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_tag", 128'(out_tag), 128'd0);
    chk("rst_out_mode", 128'(out_mode), 128'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);
    tick();

    // 1: single NR=10 block, round schedule and latency
    t = cyc;
    drive(blk(8'h11), 4'd3, 1'b1, 2'd0);
    push(blk(8'h11) ^ 128'hB, 4'd3, 1'b1, t + 45);
    @(negedge clk);
    chk("t1_in_ready", 128'(in_ready), 128'd1);
    chk("t1_iss_valid0", 128'(iss_valid), 128'd1);
    chk("t1_iss_round0", 128'(iss_round), 128'd0);
    chk("t1_iss_last0", 128'(iss_last), 128'd0);
    chk("t1_iss_mode0", 128'(iss_mode), 128'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      chk("t1_iss_valid", 128'(iss_valid), 128'((k % 4 == 0 && k <= 40) ? 1 : 0));
      if (k % 4 == 0 && k <= 40) begin
        chk("t1_iss_round", 128'(iss_round), 128'(k / 4));
        chk("t1_iss_last", 128'(iss_last), 128'((k == 40) ? 1 : 0));
      end
      tick();
    end
    wait_drain(20);

    // 2: four blocks back to back fill the credits
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      drive(blk(8'h20 + 8'(i)), 4'(4 + i), i[0], 2'd0);
      push(blk(8'h20 + 8'(i)) ^ 128'hB, 4'(4 + i), i[0], t + 45 + i);
      @(negedge clk);
      chk("t2_in_ready_adm", 128'(in_ready), 128'd1);
      chk("t2_iss_valid_adm", 128'(iss_valid), 128'd1);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 4; c <= 44; c++) begin
      @(negedge clk);
      chk("t2_in_ready_full", 128'(in_ready), 128'd0);
      chk("t2_iss_valid", 128'(iss_valid), 128'((c <= 43) ? 1 : 0));
      tick();
    end
    wait_drain(20);

    // 3: consumer stalled, six blocks offered
    out_ready = 1'b0;
    admitted  = 0;
    j         = 0;
    for (int n = 0; n < 50; n++) begin
      drive(blk(8'h30 + 8'(j)), 4'(8 + j), 1'b0, 2'd0);
      @(negedge clk);
      if (in_ready) begin
        push(blk(8'h30 + 8'(j)) ^ 128'hB, 4'(8 + j), 1'b0, -1);
        admitted++;
        j++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("t3_admitted", 128'(admitted), 128'd4);
    @(negedge clk);
    chk("t3_in_ready_stalled", 128'(in_ready), 128'd0);
    chk("t3_out_valid", 128'(out_valid), 128'd1);
    chk("t3_busy", 128'(busy), 128'd1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_in_ready_after_pop", 128'(in_ready), 128'd1);
    chk("t3_out_valid_after_pop", 128'(out_valid), 128'd1);
    tick();
    out_ready = 1'b1;
    wait_drain(20);

    // 4: NR=14 block overtaken by a later NR=10 block
    t = cyc;
    drive(blk(8'h41), 4'd1, 1'b1, 2'd2);
    @(negedge clk);
    chk("t4_in_ready_a", 128'(in_ready), 128'd1);
    tick();
    drive(blk(8'h42), 4'd2, 1'b0, 2'd0);
    @(negedge clk);
    chk("t4_in_ready_b", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    push(blk(8'h42) ^ 128'hB, 4'd2, 1'b0, t + 46);
    push(blk(8'h41) ^ 128'hF, 4'd1, 1'b1, t + 61);
    wait_drain(80);

    // 5a: NR=12 decode block; inputs change after admission
    t = cyc;
    cnt = 0;
    drive(blk(8'h51), 4'd5, 1'b0, 2'd1);
    push(blk(8'h51) ^ 128'hC, 4'd5, 1'b0, t + 53);
    @(negedge clk);
    chk("t5a_in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid  = 1'b0;
    in_mode   = 1'b1;
    in_nr_sel = 2'd2;
    cnt       = 1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (iss_valid) begin
        cnt++;
        chk("t5a_iss_mode", 128'(iss_mode), 128'd0);
      end
      tick();
    end
    chk("t5a_passes", 128'(cnt), 128'd13);
    wait_drain(20);

    // 5b: nr_sel=3 encode block behaves as NR=10
    t = cyc;
    drive(blk(8'h52), 4'd6, 1'b1, 2'd3);
    push(blk(8'h52) ^ 128'hB, 4'd6, 1'b1, t + 45);
    @(negedge clk);
    chk("t5b_in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_nr_sel = 2'd1;
    cnt       = 1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (iss_valid) begin
        cnt++;
        chk("t5b_iss_mode", 128'(iss_mode), 128'd1);
      end
      tick();
    end
    chk("t5b_passes", 128'(cnt), 128'd11);
    wait_drain(20);

    // 6: reset with one buffered and three in flight; discarded tags never appear
    out_ready = 1'b0;
    drive(blk(8'h60), 4'd12, 1'b0, 2'd0);
    tick();
    in_valid = 1'b0;
    repeat (46) tick();
    @(negedge clk);
    chk("t6_buffered", 128'(out_valid), 128'd1);
    tick();
    t = cyc;
    for (int i = 0; i < 3; i++) begin
      drive(blk(8'h61 + 8'(i)), 4'(13 + i), 1'b1, 2'd0);
      @(negedge clk);
      chk("t6_in_ready_adm", 128'(in_ready), 128'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (17) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", 128'(in_ready), 128'd0);
    chk("t6_rst_iss_valid", 128'(iss_valid), 128'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    drive(blk(8'h70), 4'd7, 1'b0, 2'd0);
    push(blk(8'h70) ^ 128'hB, 4'd7, 1'b0, t + 66);
    @(negedge clk);
    chk("t6_out_valid", 128'(out_valid), 128'd0);
    chk("t6_busy", 128'(busy), 128'd0);
    chk("t6_in_ready", 128'(in_ready), 128'd1);
    chk("t6_out_tag", 128'(out_tag), 128'd0);
    tick();
    in_valid = 1'b0;
    wait_drain(60);
    repeat (20) tick();

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
